// File: rtl/ddram_arb_pkg.sv
// Shared widths, FSM states and the latched transfer payload for the ddram client arbiter.
package ddram_arb_pkg;

    localparam int unsigned ADDR_W  = 28;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned GID_W   = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        RELEASE
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WE
    } op_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        op_t               op;
    } xfer_t;

endpackage

// File: rtl/ddram_arb_rr_arbiter.sv
// Round-robin grant with an optional fixed high-priority requester; owns the rotation pointer.
module ddram_arb_rr_arbiter
    import ddram_arb_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int          HIPRI = -1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_onehot_c,
    output logic [2:0]   gnt_idx_c
);

    localparam bit          HI_EN  = (HIPRI >= 0);
    localparam int unsigned HI_SEL = HI_EN ? 32'(HIPRI) : 32'd0;

    logic [2:0]         ptr_q, ptr_d;
    logic [MAX_REQ-1:0] req_w;
    logic [MAX_REQ-1:0] gnt_w;
    logic [3:0]         cand;
    logic [3:0]         nxt;
    logic [2:0]         win;
    logic               found;

    // Scan from the pointer with wrap; the high-priority requester overrides the scan.
    always_comb begin
        req_w = MAX_REQ'(req_i);
        win   = ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(N)) begin
                cand = cand - 4'(N);
            end
            if (!found && req_w[cand[2:0]]) begin
                win   = cand[2:0];
                found = 1'b1;
            end
        end
        if (HI_EN && req_w[3'(HI_SEL)]) begin
            win = 3'(HI_SEL);
        end
        gnt_w        = MAX_REQ'(1) << win;
        gnt_onehot_c = found ? gnt_w[N-1:0] : '0;
        gnt_idx_c    = win;
        nxt          = {1'b0, win} + 4'd1;
        ptr_d        = ptr_q;
        if (en_i && found) begin
            ptr_d = (nxt >= 4'(N)) ? 3'd0 : nxt[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ddram_arb.sv
// Shares one ddram byte client port between NREQ level-handshake requesters,
// turning req/ack into re-armed rd/we strobes.
module ddram_arb
    import ddram_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int          HIPRI = -1
) (
    input  logic                     DDRAM_CLK,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_rd,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_din,
    output logic [NREQ-1:0]          req_ack,
    output logic [DATA_W-1:0]        req_dout,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_din,
    output logic                     ram_rd,
    output logic                     ram_we,
    input  logic [DATA_W-1:0]        ram_dout,
    input  logic                     ram_ready,
    input  logic                     ram_busy,
    output logic [GID_W-1:0]         grant_id
);

    state_t              state_q, state_d;
    xfer_t               xfer_q, xfer_d;
    xfer_t               req_xfer_c;
    logic [NREQ-1:0]     own_q, own_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [GID_W-1:0]    grant_id_q, grant_id_d;
    logic                rd_q, rd_d;
    logic                we_q, we_d;
    logic                strobe_on_c;
    logic                arb_en_c;
    logic [NREQ-1:0]     eligible_c;
    logic [NREQ-1:0]     gnt_oh_c;
    logic [2:0]          gnt_idx_c;
    logic [ADDR_W-1:0]   addr_arr [NREQ];
    logic [DATA_W-1:0]   din_arr  [NREQ];

    assign eligible_c = req_rd | req_we;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign din_arr[g]  = req_din[g*DATA_W +: DATA_W];
    end

    ddram_arb_rr_arbiter #(
        .N     (NREQ),
        .HIPRI (HIPRI)
    ) u_rr (
        .clk          (DDRAM_CLK),
        .rst_n        (reset_n),
        .req_i        (eligible_c),
        .en_i         (arb_en_c),
        .gnt_onehot_c (gnt_oh_c),
        .gnt_idx_c    (gnt_idx_c)
    );

    // Operand mux for the current winner; a write request dominates a simultaneous read.
    always_comb begin
        req_xfer_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_oh_c[i]) begin
                req_xfer_c.addr = addr_arr[i];
                req_xfer_c.din  = din_arr[i];
                req_xfer_c.op   = req_we[i] ? OP_WE : OP_RD;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        xfer_d     = xfer_q;
        own_d      = own_q;
        grant_id_d = grant_id_q;
        dout_d     = dout_q;
        ack_d      = '0;
        arb_en_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|eligible_c) && ram_ready) begin
                    arb_en_c   = 1'b1;
                    xfer_d     = req_xfer_c;
                    own_d      = gnt_oh_c;
                    grant_id_d = GID_W'(gnt_idx_c);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (!ram_ready) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (ram_ready) begin
                    ack_d = own_q;
                    if (xfer_q.op == OP_RD) begin
                        dout_d = ram_dout;
                    end
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // ddram must see the strobe low while not busy so its edge detector re-arms.
                if (ram_ready && !ram_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        strobe_on_c = (state_d == ISSUE) || (state_d == WAIT_LO);
        rd_d        = strobe_on_c && (xfer_d.op == OP_RD);
        we_d        = strobe_on_c && (xfer_d.op == OP_WE);
    end

    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            xfer_q     <= '0;
            own_q      <= '0;
            ack_q      <= '0;
            dout_q     <= '0;
            grant_id_q <= '0;
            rd_q       <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            xfer_q     <= xfer_d;
            own_q      <= own_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
            grant_id_q <= grant_id_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
        end
    end

    assign req_ack  = ack_q;
    assign req_dout = dout_q;
    assign ram_addr = xfer_q.addr;
    assign ram_din  = xfer_q.din;
    assign ram_rd   = rd_q;
    assign ram_we   = we_q;
    assign grant_id = grant_id_q;

endmodule
